// File: rtl/snn_pkg.sv
// Shared SNN definitions: index-width derivation and the input-driver state encoding.
// Also used by network_controller.
package snn_pkg;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        PRESENT = 2'd2
    } drv_state_t;

endpackage

// File: rtl/spike_fifo.sv
// Synchronous FIFO with push/pop/count/empty/full. Pushes are refused while full, even if a pop
// happens in the same cycle. DEPTH must be a power of two so the pointers wrap naturally.
module spike_fifo #(
    parameter  int DATA_W = 14,
    parameter  int DEPTH  = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
        if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/spike_input_driver.sv
// Buffers input-spike events and presents them one at a time to network_processor,
// holding each on input_occurred/input_index until input_ack.
module spike_input_driver
    import snn_pkg::*;
#(
    parameter  int SR_DEPTH    = 16384,
    parameter  int FIFO_DEPTH  = 16,
    parameter  int ACK_TIMEOUT = 1024,
    parameter  int CNT_WIDTH   = 16,
    localparam int IDX_W       = idx_width(SR_DEPTH),
    localparam int FCNT_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int WAIT_W      = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 ev_valid,
    input  logic [IDX_W-1:0]     ev_index,
    output logic                 ev_ready,
    output logic                 input_occurred,
    output logic [IDX_W-1:0]     input_index,
    input  logic                 input_ack,
    output logic                 fifo_empty,
    output logic [CNT_WIDTH-1:0] sent_count,
    output logic                 timeout_err
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(ACK_TIMEOUT);

    drv_state_t           state_q, state_d;
    logic                 armed_q, armed_d;
    logic                 occ_q, occ_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic [CNT_WIDTH-1:0] sent_q, sent_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 terr_q, terr_d;

    logic                 load;
    logic                 fifo_pop;
    logic [IDX_W-1:0]     fifo_head;
    logic [FCNT_W-1:0]    fifo_count;
    logic                 fifo_full;

    spike_fifo #(
        .DATA_W (IDX_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ev_valid && !fifo_full),
        .push_data (ev_index),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign ev_ready       = (fifo_count < FCNT_W'(FIFO_DEPTH));
    assign input_occurred = occ_q;
    assign input_index    = index_q;
    assign sent_count     = sent_q;
    assign timeout_err    = terr_q;

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        occ_d    = occ_q;
        index_d  = index_q;
        sent_d   = sent_q;
        wait_d   = wait_q;
        terr_d   = terr_q;
        load     = 1'b0;
        fifo_pop = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !armed_q) begin
                    armed_d = 1'b1;
                    if (!fifo_empty) load = 1'b1;
                    else             state_d = WAIT;
                end
            end
            WAIT: begin
                if (!fifo_empty) load = 1'b1;
            end
            PRESENT: begin
                if (input_ack) begin
                    sent_d = sent_q + CNT_WIDTH'(1);
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        occ_d   = 1'b0;
                        state_d = WAIT;
                    end
                end else if (wait_q != WAIT_MAX) begin
                    // The counter saturates at the limit; the flag stays sticky until reset.
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_d == WAIT_MAX) terr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d  = PRESENT;
            occ_d    = 1'b1;
            index_d  = fifo_head;
            fifo_pop = 1'b1;
            wait_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            occ_q   <= 1'b0;
            index_q <= '0;
            sent_q  <= '0;
            wait_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            occ_q   <= occ_d;
            index_q <= index_d;
            sent_q  <= sent_d;
            wait_q  <= wait_d;
            terr_q  <= terr_d;
        end
    end

endmodule

// File: tb/tb_spike_input_driver.sv
// Scoreboard bench for spike_input_driver: accepted pushes queue expected indices, and a
// negedge monitor compares every acknowledged presentation against the queue head.
module tb_spike_input_driver;

    localparam int IDX_W = 14;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             ev_valid;
    logic [IDX_W-1:0] ev_index;
    logic             ev_ready;
    logic             input_occurred;
    logic [IDX_W-1:0] input_index;
    logic             input_ack;
    logic             fifo_empty;
    logic [15:0]      sent_count;
    logic             timeout_err;

    int               errors = 0;
    int               checks = 0;
    logic [IDX_W-1:0] exp_q[$];

    spike_input_driver dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .ev_valid       (ev_valid),
        .ev_index       (ev_index),
        .ev_ready       (ev_ready),
        .input_occurred (input_occurred),
        .input_index    (input_index),
        .input_ack      (input_ack),
        .fifo_empty     (fifo_empty),
        .sent_count     (sent_count),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: a presentation is consumed at the next edge when occurred and ack are both high.
    always @(negedge clk) begin
        if (!reset && input_occurred && input_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got index %0d, expected no event (t=%0t)", input_index, $time);
            end else begin
                check("sb_index", 32'(input_index), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push_ev(input logic [IDX_W-1:0] idx);
        bit ok = 1'b0;
        ev_valid = 1'b1;
        ev_index = idx;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            ok = ev_ready;
            step();
            if (ok) break;
        end
        ev_valid = 1'b0;
        if (ok) exp_q.push_back(idx);
        else    check("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_occ();
        bit seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (input_occurred) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) check("wait_occurred", 32'(seen), 32'd1);
    endtask

    task automatic ack_one(input int delay);
        wait_occ();
        repeat (delay) step();
        input_ack = 1'b1;
        step();
        input_ack = 1'b0;
    endtask

    task automatic drain_with_ack();
        input_ack = 1'b1;
        for (int i = 0; i < 64 && input_occurred; i++) step();
        input_ack = 1'b0;
        check("drain_done", 32'(input_occurred), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        ev_valid  = 1'b0;
        ev_index  = '0;
        input_ack = 1'b0;

        // Test 1: reset values, pre-start buffering, ordered delivery with delayed acks.
        do_reset();
        check("rst_ev_ready", 32'(ev_ready), 32'd1);
        check("rst_occurred", 32'(input_occurred), 32'd0);
        check("rst_index", 32'(input_index), 32'd0);
        check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        check("rst_sent_count", 32'(sent_count), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        push_ev(14'd3);
        push_ev(14'd7);
        push_ev(14'd9);
        check("t1_no_present_before_start", 32'(input_occurred), 32'd0);
        pulse_start();
        for (int k = 0; k < 3; k++) ack_one(2);
        check("t1_sent_count", 32'(sent_count), 32'd3);
        check("t1_fifo_empty", 32'(fifo_empty), 32'd1);
        check("t1_occurred_low", 32'(input_occurred), 32'd0);

        // Test 2: full FIFO, ack held high, one event per cycle.
        do_reset();
        for (int k = 0; k < 16; k++) push_ev(14'(100 + k));
        check("t2_ev_ready_full", 32'(ev_ready), 32'd0);
        input_ack = 1'b1;
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            check("t2_back_to_back", 32'(input_occurred), 32'd1);
            step();
        end
        input_ack = 1'b0;
        check("t2_occurred_low", 32'(input_occurred), 32'd0);
        check("t2_sent_count", 32'(sent_count), 32'd16);
        check("t2_ev_ready", 32'(ev_ready), 32'd1);

        // Test 3: ack withheld until timeout, then a late ack.
        do_reset();
        pulse_start();
        push_ev(14'd5);
        wait_occ();
        repeat (1023) step();
        check("t3_no_timeout_1023", 32'(timeout_err), 32'd0);
        step();
        check("t3_timeout_1024", 32'(timeout_err), 32'd1);
        check("t3_index_held", 32'(input_index), 32'd5);
        check("t3_still_presented", 32'(input_occurred), 32'd1);
        ack_one(0);
        check("t3_sent_count", 32'(sent_count), 32'd1);
        check("t3_timeout_sticky", 32'(timeout_err), 32'd1);

        // Test 4: full FIFO, push offered in the same cycle as a pop.
        do_reset();
        for (int k = 0; k < 16; k++) push_ev(14'(200 + k));
        pulse_start();
        push_ev(14'd216);
        check("t4_full_again", 32'(ev_ready), 32'd0);
        ev_valid  = 1'b1;
        ev_index  = 14'd999;
        input_ack = 1'b1;
        @(negedge clk);
        check("t4_push_refused", 32'(ev_ready), 32'd0);
        step();
        ev_valid = 1'b0;
        check("t4_count15_ready", 32'(ev_ready), 32'd1);
        check("t4_next_index", 32'(input_index), 32'd201);
        drain_with_ack();
        check("t4_sent_count", 32'(sent_count), 32'd17);

        // Test 5: reset while 42 is presented with four buffered behind it.
        do_reset();
        push_ev(14'd41);
        push_ev(14'd42);
        for (int k = 1; k <= 4; k++) push_ev(14'(k));
        pulse_start();
        ack_one(0);
        check("t5_presenting_42", 32'(input_index), 32'd42);
        do_reset();
        check("t5_occurred_low", 32'(input_occurred), 32'd0);
        check("t5_fifo_empty", 32'(fifo_empty), 32'd1);
        check("t5_sent_count", 32'(sent_count), 32'd0);
        push_ev(14'd77);
        repeat (5) step();
        check("t5_needs_start", 32'(input_occurred), 32'd0);
        pulse_start();
        ack_one(0);
        check("t5_resume_sent", 32'(sent_count), 32'd1);

        // Test 6: spurious acks while idle, then the maximum index.
        do_reset();
        input_ack = 1'b1;
        repeat (3) step();
        input_ack = 1'b0;
        check("t6_idle_ack_no_count", 32'(sent_count), 32'd0);
        push_ev(14'd16383);
        input_ack = 1'b1;
        step();
        input_ack = 1'b0;
        check("t6_buffered_ack_no_count", 32'(sent_count), 32'd0);
        check("t6_not_popped", 32'(fifo_empty), 32'd0);
        pulse_start();
        check("t6_max_index", 32'(input_index), 32'd16383);
        ack_one(1);
        check("t6_sent_count", 32'(sent_count), 32'd1);

        repeat (2) step();
        check("sb_all_delivered", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
